vector_regfile: RTL and testbench



---
 rtl/vp_pkg.sv | 26 ++
 rtl/vector_regfile_if.sv | 14 +
 rtl/vrf_stream_ctrl.sv | 93 +++++++++
 rtl/vector_regfile.sv | 97 +++++++++
 tb/tb_vector_regfile.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared vector-pipeline definitions: geometry, vector funct codes and the
// element-streaming FSM state type.
package vp_pkg;
    localparam int NUM_VREG = 8;
    localparam int LANES    = 8;
    localparam int DATA_W   = 32;
    localparam int VADDR_W  = $clog2(NUM_VREG);
    localparam int ELEM_W   = $clog2(LANES);
    localparam int CNT_W    = 5;

    localparam logic [5:0] ADD_V = 6'b110000;
    localparam logic [5:0] SUB_V = 6'b110001;
    localparam logic [5:0] AND_V = 6'b110010;
    localparam logic [5:0] OR_V  = 6'b110011;
    localparam logic [5:0] XOR_V = 6'b110100;
    localparam logic [5:0] MUL_V = 6'b110101;

    typedef logic [DATA_W-1:0] elem_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_DONE
    } stream_state_e;
endpackage

// File: rtl/vector_regfile_if.sv
// Memory-side element stream between the vector register file and the load/store unit.
interface vector_regfile_if;
    import vp_pkg::*;

    elem_t ld_data;
    logic  ld_valid;
    logic  ld_ready;
    elem_t st_data;
    logic  st_valid;
    logic  st_ready;

    modport master (output ld_data, ld_valid, st_ready, input ld_ready, st_data, st_valid);
    modport slave  (input ld_data, ld_valid, st_ready, output ld_ready, st_data, st_valid);
endinterface

// File: rtl/vrf_stream_ctrl.sv
// Element-streaming sequencer: walks one vector register element by element
// for a streamed load or store.
//   state   | meaning
//   S_IDLE  | waiting for ld_start / st_start, cnt held at 0
//   S_LOAD  | accepting one inbound element per ld_valid beat
//   S_STORE | presenting element cnt, advancing on st_ready
//   S_DONE  | one-cycle completion pulse, cnt held at last index
module vrf_stream_ctrl
    import vp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_start,
    input  logic               st_start,
    input  logic [VADDR_W-1:0] ls_vreg,
    input  logic               ld_valid,
    input  logic               st_ready,
    output logic               ld_ready,
    output logic               st_valid,
    output logic [CNT_W-1:0]   cnt,
    output logic               busy,
    output logic               done,
    output logic               elem_we,
    output logic [ELEM_W-1:0]  elem_idx,
    output logic [VADDR_W-1:0] elem_vreg
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    stream_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VADDR_W-1:0] vreg_q, vreg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vreg_q  <= vreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vreg_d   = vreg_q;
        ld_ready = 1'b0;
        st_valid = 1'b0;
        done     = 1'b0;
        elem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // load has priority; a simultaneous store request is dropped
                if (ld_start) begin
                    state_d = S_LOAD;
                    vreg_d  = ls_vreg;
                end else if (st_start) begin
                    state_d = S_STORE;
                    vreg_d  = ls_vreg;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    elem_we = 1'b1;
                    if (cnt_q == LAST) state_d = S_DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            S_STORE: begin
                st_valid = 1'b1;
                if (st_ready) begin
                    if (cnt_q == LAST) state_d = S_DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt       = cnt_q;
    assign busy      = (state_q != S_IDLE);
    assign elem_idx  = cnt_q[ELEM_W-1:0];
    assign elem_vreg = vreg_q;
endmodule

// File: rtl/vector_regfile.sv
// 8 x 8 x 32-bit vector register file: two combinational vector read ports, one
// ALU writeback port and a streamed element load/store path. Optional VRF_BYPASS_EN.
module vector_regfile
    import vp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VADDR_W-1:0] rd_addr1,
    input  logic [VADDR_W-1:0] rd_addr2,
    output elem_t              read_data_v1_0, read_data_v1_1, read_data_v1_2, read_data_v1_3,
    output elem_t              read_data_v1_4, read_data_v1_5, read_data_v1_6, read_data_v1_7,
    output elem_t              read_data_v2_0, read_data_v2_1, read_data_v2_2, read_data_v2_3,
    output elem_t              read_data_v2_4, read_data_v2_5, read_data_v2_6, read_data_v2_7,
    input  logic               wr_en,
    input  logic [VADDR_W-1:0] wr_addr,
    input  elem_t              alu_result_v0, alu_result_v1, alu_result_v2, alu_result_v3,
    input  elem_t              alu_result_v4, alu_result_v5, alu_result_v6, alu_result_v7,
    input  logic               ld_start,
    input  logic               st_start,
    input  logic [VADDR_W-1:0] ls_vreg,
    output logic [CNT_W-1:0]   cnt,
    output logic               busy,
    output logic               done,
    vector_regfile_if.slave    bus
);
    elem_t              vreg_q [NUM_VREG][LANES];
    elem_t              alu_vec [LANES];
    elem_t              rd1 [LANES];
    elem_t              rd2 [LANES];
    logic               elem_we;
    logic [ELEM_W-1:0]  elem_idx;
    logic [VADDR_W-1:0] elem_vreg;

    vrf_stream_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .st_start  (st_start),
        .ls_vreg   (ls_vreg),
        .ld_valid  (bus.ld_valid),
        .st_ready  (bus.st_ready),
        .ld_ready  (bus.ld_ready),
        .st_valid  (bus.st_valid),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .elem_we   (elem_we),
        .elem_idx  (elem_idx),
        .elem_vreg (elem_vreg)
    );

    assign alu_vec[0] = alu_result_v0;  assign alu_vec[1] = alu_result_v1;
    assign alu_vec[2] = alu_result_v2;  assign alu_vec[3] = alu_result_v3;
    assign alu_vec[4] = alu_result_v4;  assign alu_vec[5] = alu_result_v5;
    assign alu_vec[6] = alu_result_v6;  assign alu_vec[7] = alu_result_v7;

    // streamed element is written after the ALU vector so it wins its lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VREG; v++)
                for (int l = 0; l < LANES; l++)
                    vreg_q[v][l] <= '0;
        end else begin
            if (wr_en)
                for (int l = 0; l < LANES; l++)
                    vreg_q[wr_addr][l] <= alu_vec[l];
            if (elem_we)
                vreg_q[elem_vreg][elem_idx] <= bus.ld_data;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rd1[l] = vreg_q[rd_addr1][l];
            rd2[l] = vreg_q[rd_addr2][l];
`ifdef VRF_BYPASS_EN
            if (wr_en && wr_addr == rd_addr1) rd1[l] = alu_vec[l];
            if (wr_en && wr_addr == rd_addr2) rd2[l] = alu_vec[l];
            if (elem_we && elem_idx == l[ELEM_W-1:0]) begin
                if (elem_vreg == rd_addr1) rd1[l] = bus.ld_data;
                if (elem_vreg == rd_addr2) rd2[l] = bus.ld_data;
            end
`endif
        end
    end

    assign bus.st_data = bus.st_valid ? vreg_q[elem_vreg][elem_idx] : '0;

    assign read_data_v1_0 = rd1[0];  assign read_data_v1_1 = rd1[1];
    assign read_data_v1_2 = rd1[2];  assign read_data_v1_3 = rd1[3];
    assign read_data_v1_4 = rd1[4];  assign read_data_v1_5 = rd1[5];
    assign read_data_v1_6 = rd1[6];  assign read_data_v1_7 = rd1[7];
    assign read_data_v2_0 = rd2[0];  assign read_data_v2_1 = rd2[1];
    assign read_data_v2_2 = rd2[2];  assign read_data_v2_3 = rd2[3];
    assign read_data_v2_4 = rd2[4];  assign read_data_v2_5 = rd2[5];
    assign read_data_v2_6 = rd2[6];  assign read_data_v2_7 = rd2[7];
endmodule

// File: tb/tb_vector_regfile.sv
// Self-checking bench for vector_regfile against a behavioural register-file model.
module tb_vector_regfile;
    import vp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  rd_addr1, rd_addr2, wr_addr, ls_vreg;
    logic [31:0] rd1 [8];
    logic [31:0] rd2 [8];
    logic [31:0] alu [8];
    logic        wr_en, ld_start, st_start;
    logic [4:0]  cnt;
    logic        busy, done;

    vector_regfile_if bus ();

    vector_regfile dut (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .read_data_v1_0(rd1[0]), .read_data_v1_1(rd1[1]), .read_data_v1_2(rd1[2]), .read_data_v1_3(rd1[3]),
        .read_data_v1_4(rd1[4]), .read_data_v1_5(rd1[5]), .read_data_v1_6(rd1[6]), .read_data_v1_7(rd1[7]),
        .read_data_v2_0(rd2[0]), .read_data_v2_1(rd2[1]), .read_data_v2_2(rd2[2]), .read_data_v2_3(rd2[3]),
        .read_data_v2_4(rd2[4]), .read_data_v2_5(rd2[5]), .read_data_v2_6(rd2[6]), .read_data_v2_7(rd2[7]),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .alu_result_v0(alu[0]), .alu_result_v1(alu[1]), .alu_result_v2(alu[2]), .alu_result_v3(alu[3]),
        .alu_result_v4(alu[4]), .alu_result_v5(alu[5]), .alu_result_v6(alu[6]), .alu_result_v7(alu[7]),
        .ld_start(ld_start), .st_start(st_start), .ls_vreg(ls_vreg),
        .cnt(cnt), .busy(busy), .done(done), .bus(bus)
    );

    // reference: register contents plus stream phase (0 idle, 1 load, 2 store, 3 done)
    logic [31:0] m [8][8];
    int          mode, idx, mvreg;
    int          n_cmp = 0, n_err = 0, done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a, input int l);
        logic [31:0] v;
        v = m[a][l];
`ifdef VRF_BYPASS_EN
        if (wr_en && wr_addr == a) v = alu[l];
        if (mode == 1 && bus.ld_valid && mvreg == int'(a) && idx == l) v = bus.ld_data;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 8; v++) for (int l = 0; l < 8; l++) m[v][l] = '0;
        mode = 0; idx = 0; mvreg = 0;
    endtask

    task automatic model_edge();
        if (wr_en) for (int l = 0; l < 8; l++) m[wr_addr][l] = alu[l];
        case (mode)
            0: if (ld_start || st_start) begin
                   mode = ld_start ? 1 : 2; mvreg = int'(ls_vreg); idx = 0;
               end
            1: if (bus.ld_valid) begin
                   m[mvreg][idx] = bus.ld_data;
                   if (idx == 7) mode = 3; else idx++;
               end
            2: if (bus.st_ready) begin
                   if (idx == 7) mode = 3; else idx++;
               end
            default: begin mode = 0; idx = 0; end
        endcase
    endtask

    task automatic check(input string tag);
        for (int l = 0; l < 8; l++) begin
            chk({tag, "/rd1"}, rd1[l], exp_rd(rd_addr1, l));
            chk({tag, "/rd2"}, rd2[l], exp_rd(rd_addr2, l));
        end
        chk({tag, "/busy"}, 32'(busy), 32'(mode != 0));
        chk({tag, "/cnt"}, 32'(cnt), 32'(idx));
        chk({tag, "/done"}, 32'(done), 32'(mode == 3));
        chk({tag, "/ld_ready"}, 32'(bus.ld_ready), 32'(mode == 1));
        chk({tag, "/st_valid"}, 32'(bus.st_valid), 32'(mode == 2));
        if (mode == 2) chk({tag, "/st_data"}, bus.st_data, m[mvreg][idx]);
        if (done) done_seen++;
    endtask

    task automatic cycle(input string tag);
        #1;
        check(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; ld_start = 0; st_start = 0;
        bus.ld_valid = 0; bus.st_ready = 0; bus.ld_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got [$];
        int d0, r;

        idle_inputs();
        wr_addr = 0; ls_vreg = 0; rd_addr1 = 0; rd_addr2 = 0;
        for (int l = 0; l < 8; l++) alu[l] = '0;
        rst_n = 0;
        model_reset();
        #3;
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
            #1 check("reset");
            chk("reset/st_data", bus.st_data, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1;

        // ALU writeback of 1..8 into vreg3
        wr_en = 1; wr_addr = 3; rd_addr1 = 3; rd_addr2 = 0;
        for (int l = 0; l < 8; l++) alu[l] = 32'(l + 1);
        cycle("alu_wr");
        wr_en = 0;
        #1;
        for (int l = 0; l < 8; l++) chk("alu_rd", rd1[l], 32'(l + 1));
        cycle("alu_rd_model");

        repeat (12) begin
            wr_en = 1'($urandom); wr_addr = 3'($urandom);
            rd_addr1 = 3'($urandom); rd_addr2 = 3'($urandom);
            for (int l = 0; l < 8; l++) alu[l] = $urandom;
            cycle("alu_rand");
        end
        wr_en = 0;

        // directed load of 0x10..0x17 into vreg5
        ld_start = 1; ls_vreg = 5; bus.ld_valid = 1; bus.ld_data = 32'h10; rd_addr1 = 5;
        cycle("ld_start");
        ld_start = 0;
        for (int k = 0; k < 8; k++) begin
            bus.ld_data = 32'h10 + 32'(k);
            cycle("ld_beat");
        end
        bus.ld_valid = 0;
        chk("ld_done_at_9", 32'(done), 32'h1);
        cycle("ld_done");
        #1;
        for (int l = 0; l < 8; l++) chk("ld_vreg5", rd1[l], 32'h10 + 32'(l));

        // store of vreg5 with st_ready stalled on cycles 2..4
        st_start = 1; ls_vreg = 5;
        cycle("st_start");
        st_start = 0;
        for (int c = 1; c <= 30 && !done; c++) begin
            bus.st_ready = !(c >= 2 && c <= 4);
            #1;
            if (bus.st_valid && bus.st_ready) got.push_back(bus.st_data);
            if (bus.st_valid && !bus.st_ready) chk("st_hold", bus.st_data, 32'h11);
            cycle("st_beat");
        end
        bus.st_ready = 0;
        chk("st_done", 32'(done), 32'h1);
        chk("st_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size(); k++) chk("st_order", got[k], 32'h10 + 32'(k));
        cycle("st_done");

        // simultaneous starts: load wins, later store request while busy is dropped
        d0 = done_seen;
        ld_start = 1; st_start = 1; ls_vreg = 2;
        cycle("both_start");
        chk("both_is_load", 32'(bus.ld_ready), 32'h1);
        ld_start = 0;
        for (int c = 0; c < 60 && mode != 0; c++) begin
            st_start = (mode != 3);
            bus.ld_valid = 1'($urandom); bus.ld_data = $urandom;
            cycle("both_run");
        end
        st_start = 0; bus.ld_valid = 0;
        repeat (3) cycle("both_tail");
        chk("both_one_done", 32'(done_seen - d0), 32'd1);

        // random load with colliding ALU writes, then random store
        repeat (2) begin
            r = $urandom_range(0, 7);
            ld_start = 1; ls_vreg = 3'(r); rd_addr1 = 3'(r); rd_addr2 = 3'($urandom);
            cycle("rld_start");
            ld_start = 0;
            for (int c = 0; c < 100 && mode != 0; c++) begin
                bus.ld_valid = 1'($urandom); bus.ld_data = $urandom;
                wr_en = ($urandom_range(0, 2) == 0);
                wr_addr = $urandom_range(0, 1) ? 3'(r) : 3'($urandom);
                for (int l = 0; l < 8; l++) alu[l] = $urandom;
                cycle("rld_run");
            end
            wr_en = 0; bus.ld_valid = 0;
            chk("rld_finished", 32'(busy), 32'h0);
            st_start = 1; ls_vreg = 3'($urandom);
            cycle("rst_start");
            st_start = 0;
            for (int c = 0; c < 100 && mode != 0; c++) begin
                bus.st_ready = 1'($urandom);
                wr_en = ($urandom_range(0, 3) == 0); wr_addr = 3'($urandom);
                for (int l = 0; l < 8; l++) alu[l] = $urandom;
                cycle("rst_run");
            end
            wr_en = 0; bus.st_ready = 0;
            chk("rst_finished", 32'(busy), 32'h0);
        end

        // asynchronous reset at cnt=4 during a load
        ld_start = 1; ls_vreg = 6; bus.ld_valid = 1; rd_addr1 = 6; rd_addr2 = 3;
        cycle("arst_start");
        ld_start = 0;
        for (int c = 0; c < 20 && idx != 4; c++) begin
            bus.ld_data = $urandom;
            cycle("arst_load");
        end
        chk("arst_cnt4", 32'(cnt), 32'd4);
        d0 = done_seen;
        #1 rst_n = 0;
        model_reset();
        #1;
        check("arst");
        chk("arst/st_data", bus.st_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        idle_inputs();
        repeat (12) cycle("post_arst");
        chk("arst_no_done", 32'(done_seen - d0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
